// File: rtl/pll_reset_seq_if.sv
// Signal bundle between the PLL reset sequencer and its consumer.
// The slave side is the sequencer. The master side drives locked and observes the reset outputs.
`timescale 1ns/1ps
interface pll_reset_seq_if #(
  parameter int LOSS_W = 8
);
  logic              locked;
  logic              rst_out;
  logic              ready;
  logic [1:0]        state;
  logic [LOSS_W-1:0] loss_count;

  modport master (
    output locked,
    input  rst_out,
    input  ready,
    input  state,
    input  loss_count
  );

  modport slave (
    input  locked,
    output rst_out,
    output ready,
    output state,
    output loss_count
  );
endinterface

// File: rtl/pll_reset_seq.sv
// Stretched, synchronous-release reset generator for the PLL clock domain.
// It qualifies PLL lock, holds reset for a fixed time, and counts lock losses.
//   state  | meaning
//   IDLE   | reset asserted, waiting for synchronized lock
//   SETTLE | lock seen, counting LOCK_CYCLES consecutive locked cycles
//   HOLD   | lock qualified, reset still held for HOLD_CYCLES
//   RUN    | reset released, ready high
`timescale 1ns/1ps
module pll_reset_seq #(
  parameter int LOCK_CYCLES = 16,
  parameter int HOLD_CYCLES = 8,
  parameter int LOSS_W      = 8
) (
  input  logic             clock,
  input  logic             reset,
  pll_reset_seq_if.slave   bus
);

  localparam int MAX_C = (LOCK_CYCLES > HOLD_CYCLES) ? LOCK_CYCLES : HOLD_CYCLES;
  localparam int CW    = (MAX_C > 1) ? $clog2(MAX_C) : 1;

  localparam logic [CW-1:0]     LOCK_TC  = CW'(LOCK_CYCLES - 1);
  localparam logic [CW-1:0]     HOLD_TC  = CW'(HOLD_CYCLES - 1);
  localparam logic [LOSS_W-1:0] LOSS_MAX = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2,
    RUN    = 2'd3
  } state_t;

  state_t            r_state;
  logic [CW-1:0]     r_cnt;
  logic              r_sync1;
  logic              r_sync2;
  logic              r_rst_out;
  logic              r_ready;
  logic [LOSS_W-1:0] r_loss;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_rst_out <= 1'b1;
      r_ready   <= 1'b0;
      r_loss    <= '0;
    end else begin
      r_sync1 <= bus.locked;
      r_sync2 <= r_sync1;

      case (r_state)
        IDLE: begin
          r_cnt     <= '0;
          r_rst_out <= 1'b1;
          r_ready   <= 1'b0;
          if (r_sync2) begin
            r_state <= SETTLE;
          end
        end

        SETTLE: begin
          if (!r_sync2) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else if (r_cnt == LOCK_TC) begin
            r_state <= HOLD;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        HOLD: begin
          if (!r_sync2) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else if (r_cnt == HOLD_TC) begin
            // Release reset and raise ready on the same edge so they never overlap.
            r_state   <= RUN;
            r_cnt     <= '0;
            r_rst_out <= 1'b0;
            r_ready   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        RUN: begin
          if (!r_sync2) begin
            r_state   <= IDLE;
            r_rst_out <= 1'b1;
            r_ready   <= 1'b0;
            if (r_loss != LOSS_MAX) begin
              r_loss <= r_loss + 1'b1;
            end
          end
        end

        default: begin
          r_state   <= IDLE;
          r_cnt     <= '0;
          r_rst_out <= 1'b1;
          r_ready   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rst_out    = r_rst_out;
  assign bus.ready      = r_ready;
  assign bus.state      = r_state;
  assign bus.loss_count = r_loss;

endmodule
